// File: rtl/fifo_read_stream_adapter.sv
// Read-side adapter: turns the async FIFO pop interface into a registered
// valid/ready stream through a two-entry main/skid buffer.
module fifo_read_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  read_clock,
    input  logic                  read_reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_read_empty,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            buffered_count,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_word_count;

    logic w_pop;
    logic w_fire;

    // Pop decision uses only registered occupancy, never out_ready.
    assign w_pop  = read_reset_n && !fifo_read_empty && (r_state != ST_TWO);
    assign w_fire = r_valid && out_ready;

    assign fifo_read_enable = w_pop;
    assign out_data         = r_main;
    assign out_valid        = r_valid;
    assign buffered_count   = r_state;
    assign word_count       = r_word_count;

    always_ff @(posedge read_clock) begin
        if (!read_reset_n) begin
            r_state      <= ST_EMPTY;
            r_main       <= '0;
            r_skid       <= '0;
            r_valid      <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_fire) begin
                r_word_count <= r_word_count + CNT_WIDTH'(1);
            end
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_pop) begin
                        r_main  <= fifo_read_data;
                        r_valid <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_fire) begin
                        r_main <= fifo_read_data;
                    end else if (w_pop) begin
                        r_skid  <= fifo_read_data;
                        r_state <= ST_TWO;
                    end else if (w_fire) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_fire) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
